// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1 TAP controller: 16-state TMS walker with registered IR/DR strobes.
// Build option TAP_STATE_DEBUG_EN exposes the raw state and a consecutive-TMS=1 counter.
module jtag_tap_ctrl #(
    parameter int unsigned STATE_W = 4
) (
    input  logic               TCK,
    input  logic               TRST,
    input  logic               TMS,
    output logic               tlr_reset,
    output logic               test_reset,
    output logic               ir_capture,
    output logic               ir_shift,
    output logic               ir_update,
    output logic               dr_capture,
    output logic               dr_shift,
    output logic               dr_update,
    output logic               select_ir,
    output logic               tdo_en
`ifdef TAP_STATE_DEBUG_EN
    ,
    output logic [STATE_W-1:0] tap_state,
    output logic [2:0]         tlr_count
`endif
);

    typedef enum logic [STATE_W-1:0] {
        StTlr     = 4'hF,
        StRti     = 4'hC,
        StSelDr   = 4'h7,
        StCapDr   = 4'h6,
        StShDr    = 4'h2,
        StEx1Dr   = 4'h1,
        StPauseDr = 4'h3,
        StEx2Dr   = 4'h0,
        StUpdDr   = 4'h5,
        StSelIr   = 4'h4,
        StCapIr   = 4'hE,
        StShIr    = 4'hA,
        StEx1Ir   = 4'h9,
        StPauseIr = 4'hB,
        StEx2Ir   = 4'h8,
        StUpdIr   = 4'hD
    } tap_state_e;

    tap_state_e state_q, state_d;
    logic       prev_was_tlr_q;

    always_comb begin
        state_d = StTlr;
        case (state_q)
            StTlr:     state_d = TMS ? StTlr   : StRti;
            StRti:     state_d = TMS ? StSelDr : StRti;
            StSelDr:   state_d = TMS ? StSelIr : StCapDr;
            StCapDr:   state_d = TMS ? StEx1Dr : StShDr;
            StShDr:    state_d = TMS ? StEx1Dr : StShDr;
            StEx1Dr:   state_d = TMS ? StUpdDr : StPauseDr;
            StPauseDr: state_d = TMS ? StEx2Dr : StPauseDr;
            StEx2Dr:   state_d = TMS ? StUpdDr : StShDr;
            StUpdDr:   state_d = TMS ? StSelDr : StRti;
            StSelIr:   state_d = TMS ? StTlr   : StCapIr;
            StCapIr:   state_d = TMS ? StEx1Ir : StShIr;
            StShIr:    state_d = TMS ? StEx1Ir : StShIr;
            StEx1Ir:   state_d = TMS ? StUpdIr : StPauseIr;
            StPauseIr: state_d = TMS ? StEx2Ir : StPauseIr;
            StEx2Ir:   state_d = TMS ? StUpdIr : StShIr;
            StUpdIr:   state_d = TMS ? StSelDr : StRti;
            default:   state_d = StTlr;
        endcase
    end

    // Outputs are registered from state_d so they change on the same edge as state_q.
    always_ff @(posedge TCK) begin
        if (TRST) begin
            state_q        <= StTlr;
            prev_was_tlr_q <= 1'b0;
            tlr_reset      <= 1'b1;
            test_reset     <= 1'b0;
            ir_capture     <= 1'b0;
            ir_shift       <= 1'b0;
            ir_update      <= 1'b0;
            dr_capture     <= 1'b0;
            dr_shift       <= 1'b0;
            dr_update      <= 1'b0;
            select_ir      <= 1'b0;
            tdo_en         <= 1'b0;
        end else begin
            state_q        <= state_d;
            // prev_was_tlr_q stays low through reset so the first free cycle in TLR pulses.
            prev_was_tlr_q <= (state_d == StTlr);
            tlr_reset      <= (state_d == StTlr);
            test_reset     <= (state_d == StTlr) && !prev_was_tlr_q;
            ir_capture     <= (state_d == StCapIr);
            ir_shift       <= (state_d == StShIr);
            ir_update      <= (state_d == StUpdIr);
            dr_capture     <= (state_d == StCapDr);
            dr_shift       <= (state_d == StShDr);
            dr_update      <= (state_d == StUpdDr);
            select_ir      <= state_d inside {StSelIr, StCapIr, StShIr, StEx1Ir,
                                              StPauseIr, StEx2Ir, StUpdIr};
            tdo_en         <= (state_d == StShIr) || (state_d == StShDr);
        end
    end

`ifdef TAP_STATE_DEBUG_EN
    assign tap_state = state_q;

    always_ff @(posedge TCK) begin
        if (TRST || !TMS) begin
            tlr_count <= 3'd0;
        end else if (tlr_count != 3'd7) begin
            tlr_count <= tlr_count + 3'd1;
        end
    end
`endif

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Scoreboard bench for jtag_tap_ctrl: stimulus queues expected strobe vectors,
// a monitor pops one per TCK edge and compares.
module tb_jtag_tap_ctrl;

    logic TCK = 1'b0;
    logic TRST = 1'b1;
    logic TMS = 1'b1;
    logic tlr_reset, test_reset, ir_capture, ir_shift, ir_update;
    logic dr_capture, dr_shift, dr_update, select_ir, tdo_en;
`ifdef TAP_STATE_DEBUG_EN
    logic [3:0] tap_state;
    logic [2:0] tlr_count;
`endif

    jtag_tap_ctrl #(.STATE_W(4)) dut (
        .TCK        (TCK),
        .TRST       (TRST),
        .TMS        (TMS),
        .tlr_reset  (tlr_reset),
        .test_reset (test_reset),
        .ir_capture (ir_capture),
        .ir_shift   (ir_shift),
        .ir_update  (ir_update),
        .dr_capture (dr_capture),
        .dr_shift   (dr_shift),
        .dr_update  (dr_update),
        .select_ir  (select_ir),
        .tdo_en     (tdo_en)
`ifdef TAP_STATE_DEBUG_EN
        ,
        .tap_state  (tap_state),
        .tlr_count  (tlr_count)
`endif
    );

    always #5 TCK = ~TCK;

    // Bit order: tlr_reset test_reset ir_cap ir_sh ir_upd dr_cap dr_sh dr_upd select_ir tdo_en
    localparam logic [9:0] E_TLR   = 10'b1000000000;
    localparam logic [9:0] E_TLRP  = 10'b1100000000;
    localparam logic [9:0] E_IDLE  = 10'b0000000000;  // RTI, SEL_DR, EX1/PAUSE/EX2_DR
    localparam logic [9:0] E_CAPDR = 10'b0000010000;
    localparam logic [9:0] E_SHDR  = 10'b0000001001;
    localparam logic [9:0] E_UPDDR = 10'b0000000100;
    localparam logic [9:0] E_IRCOL = 10'b0000000010;  // SEL_IR, EX1/PAUSE/EX2_IR
    localparam logic [9:0] E_CAPIR = 10'b0010000010;
    localparam logic [9:0] E_SHIR  = 10'b0001000011;
    localparam logic [9:0] E_UPDIR = 10'b0000100010;

    typedef struct {
        logic [9:0] exp;
        string      name;
    } sb_entry_t;

    sb_entry_t sb[$];
    int total = 0;
    int bad = 0;

    task automatic step(input logic trst, input logic tms, input logic [9:0] exp,
                        input string name);
        sb_entry_t e;
        @(negedge TCK);
        TRST = trst;
        TMS = tms;
        e.exp = exp;
        e.name = name;
        sb.push_back(e);
    endtask

    // Monitor: one queued expectation is consumed per rising TCK.
    initial begin
        sb_entry_t e;
        logic [9:0] got;
        forever begin
            @(posedge TCK);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                got = {tlr_reset, test_reset, ir_capture, ir_shift, ir_update,
                       dr_capture, dr_shift, dr_update, select_ir, tdo_en};
                total++;
                if (got !== e.exp) begin
                    bad++;
                    $display("FAIL %s: got %b expected %b", e.name, got, e.exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge TCK);

        // Reset held, then released with TMS=1
        step(1, 1, E_TLR,  "rst_hold0");
        step(1, 1, E_TLR,  "rst_hold1");
        step(0, 1, E_TLRP, "rst_release_pulse");
        step(0, 1, E_TLR,  "tlr_stay0");
        step(0, 1, E_TLR,  "tlr_stay1");

        // TLR -> SH_IR
        step(0, 0, E_IDLE,  "rti");
        step(0, 1, E_IDLE,  "sel_dr");
        step(0, 1, E_IRCOL, "sel_ir");
        step(0, 0, E_CAPIR, "cap_ir");
        step(0, 0, E_SHIR,  "sh_ir0");
        for (int i = 1; i <= 5; i++) step(0, 0, E_SHIR, $sformatf("sh_ir%0d", i));
        step(0, 1, E_IRCOL, "ex1_ir");
        step(0, 1, E_UPDIR, "upd_ir");
        step(0, 0, E_IDLE,  "rti_after_ir");

        // DR path with pause
        step(0, 1, E_IDLE,  "dr_sel");
        step(0, 0, E_CAPDR, "dr_cap");
        step(0, 0, E_SHDR,  "dr_sh0");
        step(0, 1, E_IDLE,  "dr_ex1a");
        step(0, 0, E_IDLE,  "dr_pause0");
        step(0, 0, E_IDLE,  "dr_pause1");
        step(0, 1, E_IDLE,  "dr_ex2");
        step(0, 0, E_SHDR,  "dr_sh1");
        step(0, 1, E_IDLE,  "dr_ex1b");
        step(0, 1, E_UPDDR, "dr_upd");
        step(0, 0, E_IDLE,  "dr_rti");

        // SH_DR then five TMS=1 back to TLR
        step(0, 1, E_IDLE,  "r5_sel_dr");
        step(0, 0, E_CAPDR, "r5_cap_dr");
        step(0, 0, E_SHDR,  "r5_sh_dr");
        step(0, 1, E_IDLE,  "r5_ex1_dr");
        step(0, 1, E_UPDDR, "r5_upd_dr");
        step(0, 1, E_IDLE,  "r5_sel_dr2");
        step(0, 1, E_IRCOL, "r5_sel_ir");
        step(0, 1, E_TLRP,  "r5_tlr_pulse");
        step(0, 1, E_TLR,   "r5_tlr_stay");

        // TRST while in PAUSE_IR
        step(0, 0, E_IDLE,  "p_rti");
        step(0, 1, E_IDLE,  "p_sel_dr");
        step(0, 1, E_IRCOL, "p_sel_ir");
        step(0, 0, E_CAPIR, "p_cap_ir");
        step(0, 1, E_IRCOL, "p_ex1_ir");
        step(0, 0, E_IRCOL, "p_pause_ir0");
        step(0, 0, E_IRCOL, "p_pause_ir1");
        step(1, 0, E_TLR,   "p_trst");
        step(0, 1, E_TLRP,  "p_release_pulse");
        step(0, 1, E_TLR,   "p_tlr_stay");

        // TRST during SH_IR drops ir_shift on the same edge
        step(0, 0, E_IDLE,  "s_rti");
        step(0, 1, E_IDLE,  "s_sel_dr");
        step(0, 1, E_IRCOL, "s_sel_ir");
        step(0, 0, E_CAPIR, "s_cap_ir");
        step(0, 0, E_SHIR,  "s_sh_ir");
        step(1, 0, E_TLR,   "s_trst");
        step(0, 0, E_IDLE,  "s_rti_after");

        @(negedge TCK);
        TMS = 1'b1;
        @(posedge TCK);
        #3;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
